encoded_event_fifo: RTL and testbench
=====================================

Name: encoded_event_fifo

Overview:
- Sits directly downstream of the 4-to-2 one-hot encoder and consumes its 2-bit index and its valid flag.
- Detects each new encoder event and queues the index in a small FIFO.
- Presents queued indices to the next stage over a ready/valid handshake.
- Reports dropped events when the consumer stalls and the FIFO is full.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, >= 2.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- enc_y  input  2  encoded index from the encoder.
- enc_valid  input  1  encoder valid flag; enc_y is meaningful only when high.
- out_ready  input  1  consumer can accept a word this cycle.
- out_valid  output  1  FIFO holds at least one entry.
- out_data  output  2  index at the FIFO head.
- level  output  $clog2(DEPTH+1)  current occupancy.
- full  output  1  level == DEPTH.
- overflow  output  1  sticky; set on the first dropped event.
- drop_count  output  DROP_W  dropped events, saturating.

Behaviour:
- Reset (rst high at a clk edge): pointers = 0, level = 0, out_valid = 0, full = 0, overflow = 0, drop_count = 0, prev_valid = 0, prev_y = 0.
- out_data is don't-care while out_valid = 0. The bench must not check it then.
- Memory contents are not reset.
- Reset overrides all other activity in the same cycle, including a mid-operation push or pop.
- Event detect: register prev_valid <= enc_valid and prev_y <= enc_y every cycle.
- event = enc_valid & (~prev_valid | (enc_y != prev_y)).
- A held input produces exactly one event.
- A direct change from one valid index to another produces a new event.
- enc_valid low never produces an event; enc_y is ignored while enc_valid is low.
- pop = out_valid & out_ready.
- push = event & (~full | pop).
- Push writes enc_y at the write pointer, then wr_ptr++.
- Pop advances rd_ptr.
- Both pointers wrap modulo DEPTH.
- level: +1 on push only, -1 on pop only, unchanged on both or neither.
- First-word-fall-through: out_valid = (level != 0); out_data = mem[rd_ptr], combinational from registered state.
- Latency: an event sampled at edge N into an empty FIFO gives out_valid = 1 with that data after edge N.
- Empty FIFO: push and pop cannot coincide, since pop requires out_valid.
- Full FIFO with pop in the same cycle: the event is accepted, level stays DEPTH, no drop.
- Full FIFO without pop: the event is dropped.
  - overflow <= 1 and stays 1 until reset.
  - drop_count increments and saturates at 2^DROP_W-1 (no wrap).
  - FIFO contents and pointers are unchanged.
- out_valid and out_data stay stable while out_ready is low.
- No output changes except through push, pop or reset.

Test Plan:
- Reset then idle: after rst, hold enc_valid=0 for 5 cycles -> out_valid=0, level=0, full=0, overflow=0, drop_count=0.
- Single held event: enc_y=2'b10, enc_valid=1 for 4 cycles, out_ready=0 -> level=1, out_data=2'b10 from the cycle after the first edge; no further pushes.
- Back-to-back index changes: enc_valid=1 with enc_y=0,1,3,2 on consecutive cycles, out_ready=0 -> level=4, full=1. Then out_ready=1 -> out_data sequence 0,1,3,2, then out_valid=0.
- Overflow and saturation: fill to DEPTH=4, then 3 new events with out_ready=0 -> drop_count=3, overflow=1, contents unchanged. Repeat with DROP_W=2 and 5 drops -> drop_count=3.
- Simultaneous push/pop at full: level=4, out_ready=1, new event enc_y=1 -> level stays 4, drop_count unchanged, 2'b01 emerges last. Also run 20 streaming events to check pointer wrap order.
- Reset mid-operation: level=3, push and pop active, assert rst for one cycle -> next cycle level=0, out_valid=0, overflow=0. The held enc_valid=1 is then treated as a new event (prev_valid was cleared).

Source files
------------

// File: rtl/encoded_event_fifo_if.sv
// Handshake bundle between the one-hot encoder, the event FIFO and its consumer.
// The master side drives encoder events and consumer ready; the slave side is the FIFO.
interface encoded_event_fifo_if;
    logic [1:0] enc_y;
    logic       enc_valid;
    logic       out_ready;
    logic       out_valid;
    logic [1:0] out_data;

    modport master (
        output enc_y,
        output enc_valid,
        output out_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  enc_y,
        input  enc_valid,
        input  out_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/encoded_event_fifo.sv
// Turns encoder index changes into single events, queues them in a first-word-fall-through
// FIFO and counts events lost while the consumer stalls on a full queue.
module encoded_event_fifo #(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    encoded_event_fifo_if.slave          bus,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         overflow,
    output logic [DROP_W-1:0]            drop_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [1:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             prev_valid;
    logic [1:0]       prev_y;
    logic             event_hit;
    logic             push;
    logic             pop;
    logic             drop;

    // A held index is one event; a new index or a fresh valid rising edge is another.
    assign event_hit = bus.enc_valid & (~prev_valid | (bus.enc_y != prev_y));

    assign full          = (level == LVL_W'(DEPTH));
    assign bus.out_valid = (level != '0);
    assign bus.out_data  = mem[rd_ptr];

    assign pop  = bus.out_valid & bus.out_ready;
    assign push = event_hit & (~full | pop);
    assign drop = event_hit & full & ~pop;

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= bus.enc_y;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            prev_valid <= 1'b0;
            prev_y     <= '0;
        end else begin
            prev_valid <= bus.enc_valid;
            prev_y     <= bus.enc_y;

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase

            // Drops saturate rather than wrap so a long stall never reads as a short one.
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + DROP_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_encoded_event_fifo.sv
// Directed bench for encoded_event_fifo; a second instance with a 2-bit drop counter
// shares the same stimulus to exercise counter saturation.
module tb_encoded_event_fifo;
    logic clk;
    logic rst;

    encoded_event_fifo_if bus ();
    encoded_event_fifo_if bus2 ();

    logic [2:0] level;
    logic       full;
    logic       overflow;
    logic [7:0] drop_count;
    logic [2:0] level2;
    logic       full2;
    logic       overflow2;
    logic [1:0] drop_count2;

    int checks;
    int errors;

    encoded_event_fifo #(.DEPTH(4), .DROP_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .level      (level),
        .full       (full),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    encoded_event_fifo #(.DEPTH(4), .DROP_W(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus2.slave),
        .level      (level2),
        .full       (full2),
        .overflow   (overflow2),
        .drop_count (drop_count2)
    );

    assign bus2.enc_y     = bus.enc_y;
    assign bus2.enc_valid = bus.enc_valid;
    assign bus2.out_ready = bus.out_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after a rising edge and are sampled at the next one.
    task automatic applyStimulus(input logic valid, input logic [1:0] y, input logic ready);
        bus.enc_valid = valid;
        bus.enc_y     = y;
        bus.out_ready = ready;
        @(posedge clk);
        #1;
    endtask

    task automatic fillFour();
        applyStimulus(1'b1, 2'd0, 1'b0);
        applyStimulus(1'b1, 2'd1, 1'b0);
        applyStimulus(1'b1, 2'd3, 1'b0);
        applyStimulus(1'b1, 2'd2, 1'b0);
    endtask

    task automatic drainExpect(input int w0, input int w1, input int w2, input int w3);
        int exp_words[4];
        exp_words = '{w0, w1, w2, w3};
        for (int i = 0; i < 4; i++) begin
            checkOutput("drain_valid", int'(bus.out_valid), 1);
            checkOutput("drain_data", int'(bus.out_data), exp_words[i]);
            applyStimulus(1'b0, 2'd0, 1'b1);
        end
        checkOutput("drain_empty", int'(bus.out_valid), 0);
        checkOutput("drain_level", int'(level), 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst           = 1'b1;
        bus.enc_valid = 1'b0;
        bus.enc_y     = 2'd0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 2'(i), 1'b0);
        end
        checkOutput("idle_valid", int'(bus.out_valid), 0);
        checkOutput("idle_level", int'(level), 0);
        checkOutput("idle_full", int'(full), 0);
        checkOutput("idle_overflow", int'(overflow), 0);
        checkOutput("idle_drops", int'(drop_count), 0);
        checkOutput("idle_drops2", int'(drop_count2), 0);

        // One held index must enqueue once only.
        applyStimulus(1'b1, 2'd2, 1'b0);
        checkOutput("held_valid", int'(bus.out_valid), 1);
        checkOutput("held_data", int'(bus.out_data), 2);
        checkOutput("held_level1", int'(level), 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 2'd2, 1'b0);
        end
        checkOutput("held_level_after", int'(level), 1);
        checkOutput("held_data_after", int'(bus.out_data), 2);
        applyStimulus(1'b0, 2'd0, 1'b1);
        checkOutput("held_drained", int'(bus.out_valid), 0);

        fillFour();
        checkOutput("b2b_level", int'(level), 4);
        checkOutput("b2b_full", int'(full), 1);
        drainExpect(0, 1, 3, 2);

        // Full queue with a stalled consumer: five changing events are all lost.
        fillFour();
        applyStimulus(1'b1, 2'd1, 1'b0);
        applyStimulus(1'b1, 2'd0, 1'b0);
        applyStimulus(1'b1, 2'd1, 1'b0);
        checkOutput("ovf_drops3", int'(drop_count), 3);
        checkOutput("ovf_flag", int'(overflow), 1);
        checkOutput("ovf_level", int'(level), 4);
        checkOutput("ovf_head", int'(bus.out_data), 0);
        applyStimulus(1'b1, 2'd3, 1'b0);
        applyStimulus(1'b1, 2'd0, 1'b0);
        checkOutput("ovf_drops5", int'(drop_count), 5);
        checkOutput("sat_drops2", int'(drop_count2), 3);
        checkOutput("sat_flag2", int'(overflow2), 1);
        checkOutput("sat_level2", int'(level2), 4);
        applyStimulus(1'b0, 2'd0, 1'b0);
        drainExpect(0, 1, 3, 2);
        checkOutput("ovf_sticky", int'(overflow), 1);

        fillFour();
        applyStimulus(1'b1, 2'd1, 1'b1);
        checkOutput("pp_level", int'(level), 4);
        checkOutput("pp_full", int'(full), 1);
        checkOutput("pp_drops", int'(drop_count), 5);
        drainExpect(1, 3, 2, 1);

        // Streaming at one word per cycle walks both pointers around several times.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 2'((i * 3) & 3), 1'b1);
            checkOutput("stream_level", int'(level), 1);
            checkOutput("stream_data", int'(bus.out_data), (i * 3) & 3);
        end
        applyStimulus(1'b0, 2'd0, 1'b1);
        checkOutput("stream_empty", int'(bus.out_valid), 0);

        applyStimulus(1'b1, 2'd0, 1'b0);
        applyStimulus(1'b1, 2'd1, 1'b0);
        applyStimulus(1'b1, 2'd2, 1'b0);
        checkOutput("mid_level3", int'(level), 3);
        rst = 1'b1;
        applyStimulus(1'b1, 2'd3, 1'b1);
        rst = 1'b0;
        checkOutput("mid_rst_level", int'(level), 0);
        checkOutput("mid_rst_valid", int'(bus.out_valid), 0);
        checkOutput("mid_rst_overflow", int'(overflow), 0);
        checkOutput("mid_rst_drops", int'(drop_count), 0);
        checkOutput("mid_rst_drops2", int'(drop_count2), 0);
        applyStimulus(1'b1, 2'd3, 1'b0);
        checkOutput("post_rst_level", int'(level), 1);
        checkOutput("post_rst_valid", int'(bus.out_valid), 1);
        checkOutput("post_rst_data", int'(bus.out_data), 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
